// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table capture block: default input count,
// derived widths and the controller state encoding.
package tt_pkg;

   localparam int DEF_N_IN = 7;
   localparam int TT_W     = 1 << DEF_N_IN;
   localparam int CNT_W    = DEF_N_IN + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } tt_state_e;

   function automatic int tt_width(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/tt_sweep_ctr.sv
// Pattern index and per-pattern settle counter. capture_en_o marks the cycle
// in which the current pattern's function output is sampled.
module tt_sweep_ctr
   import tt_pkg::*;
#(
   parameter int N_IN       = DEF_N_IN,
   parameter int SETTLE_CYC = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear_i,
   input  logic            run_i,
   output logic [N_IN-1:0] idx_o,
   output logic            capture_en_o,
   output logic            last_pattern_o
);

   localparam int S_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [S_W-1:0] S_LAST = S_W'(SETTLE_CYC);

   logic [N_IN-1:0] idx_q, idx_d;
   logic [S_W-1:0]  s_q, s_d;

   assign capture_en_o   = run_i && (s_q == S_LAST);
   assign last_pattern_o = &idx_q;
   assign idx_o          = idx_q;

   // The index stops on the last pattern so it is still visible in DONE.
   always_comb begin
      idx_d = idx_q;
      s_d   = s_q;
      if (clear_i) begin
         idx_d = '0;
         s_d   = '0;
      end else if (run_i) begin
         if (s_q != S_LAST) begin
            s_d = s_q + S_W'(1);
         end else begin
            s_d = '0;
            if (!last_pattern_o) begin
               idx_d = idx_q + N_IN'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q <= '0;
         s_q   <= '0;
      end else begin
         idx_q <= idx_d;
         s_q   <= s_d;
      end
   end

endmodule

// File: rtl/tt_capture.sv
// Sweeps every input pattern onto a function block, records its truth table
// and on-set size, and offers the result downstream.
module tt_capture
   import tt_pkg::*;
#(
   parameter  int N_IN       = DEF_N_IN,
   parameter  int SETTLE_CYC = 0,
   localparam int TW         = 1 << N_IN,
   localparam int CW         = N_IN + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            busy,
   output logic [N_IN-1:0] x,
   input  logic            f_in,
   output logic            tt_valid,
   input  logic            tt_ready,
   output logic [TW-1:0]   tt,
   output logic [CW-1:0]   ones,
   output logic [1:0]      dbg_state
);

   tt_state_e       state_q, state_d;
   logic [TW-1:0]   tt_q, tt_d;
   logic [CW-1:0]   ones_q, ones_d;
   logic            clear, run, capture_en, last_pattern;
   logic [N_IN-1:0] idx;

   tt_sweep_ctr #(
      .N_IN       (N_IN),
      .SETTLE_CYC (SETTLE_CYC)
   ) u_ctr (
      .clk            (clk),
      .rst_n          (rst_n),
      .clear_i        (clear),
      .run_i          (run),
      .idx_o          (idx),
      .capture_en_o   (capture_en),
      .last_pattern_o (last_pattern)
   );

   // Result handshake: tt_valid is a pure function of the registered state;
   // the result transfers on any edge where tt_valid && tt_ready, and tt/ones
   // do not change while tt_valid is high.
   always_comb begin
      state_d = state_q;
      clear   = 1'b0;
      run     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               clear   = 1'b1;
               state_d = SWEEP;
            end
         end
         SWEEP: begin
            run = 1'b1;
            if (capture_en && last_pattern) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (tt_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tt_d   = tt_q;
      ones_d = ones_q;
      if (clear) begin
         tt_d   = '0;
         ones_d = '0;
      end else if (capture_en) begin
         tt_d[idx] = f_in;
         ones_d    = ones_q + CW'(f_in);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         tt_q    <= '0;
         ones_q  <= '0;
      end else begin
         state_q <= state_d;
         tt_q    <= tt_d;
         ones_q  <= ones_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign tt_valid  = (state_q == DONE);
   assign x         = idx;
   assign tt        = tt_q;
   assign ones      = ones_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tt_capture.sv
// Bench for tt_capture: a zero-settle instance fed combinationally and a
// two-settle instance fed through a two-stage register pipeline.
module tb_tt_capture;
   import tt_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;

   logic         start0 = 1'b0, tt_ready0 = 1'b0;
   logic         busy0, tt_valid0, f_in0;
   logic [6:0]   x0;
   logic [127:0] tt0;
   logic [7:0]   ones0;
   logic [1:0]   st0;

   logic         start2 = 1'b0, tt_ready2 = 1'b0;
   logic         busy2, tt_valid2, f_in2;
   logic [6:0]   x2;
   logic [127:0] tt2;
   logic [7:0]   ones2;
   logic [1:0]   st2;

   logic [127:0] fn_tab0 = '0;
   logic [127:0] fn_tab2 = '0;
   logic         p1 = 1'b0, p2 = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] MAJ_TT = 128'hfeeaece0f8e8e880fee8e8e0f8c8a880;

   always #5 clk = ~clk;

   assign f_in0 = fn_tab0[x0];
   always @(posedge clk) begin
      p1 <= fn_tab2[x2];
      p2 <= p1;
   end
   assign f_in2 = p2;

   tt_capture #(.N_IN(7), .SETTLE_CYC(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .x(x0),
      .f_in(f_in0), .tt_valid(tt_valid0), .tt_ready(tt_ready0), .tt(tt0),
      .ones(ones0), .dbg_state(st0)
   );

   tt_capture #(.N_IN(7), .SETTLE_CYC(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .x(x2),
      .f_in(f_in2), .tt_valid(tt_valid2), .tt_ready(tt_ready2), .tt(tt2),
      .ones(ones2), .dbg_state(st2)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] tab_from_rule(input int mode);
      logic [127:0] t;
      logic [6:0]   p;
      t = '0;
      for (int i = 0; i < 128; i++) begin
         p = 7'(i);
         case (mode)
            1:       t[i] = p[0];
            2:       t[i] = p[6];
            default: t[i] = 1'b0;
         endcase
      end
      return t;
   endfunction

   function automatic int popcnt(input logic [127:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 128; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [127:0] rand_tab();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic sweep0(input logic [127:0] tab, output int cyc);
      fn_tab0 = tab;
      @(negedge clk) start0 = 1'b1;
      @(posedge clk); #1;
      check("start_busy", 128'(busy0), 128'd1);
      check("start_x", 128'(x0), 128'd0);
      @(negedge clk) start0 = 1'b0;
      cyc = 0;
      while (tt_valid0 !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic accept0();
      @(negedge clk) tt_ready0 = 1'b1;
      @(posedge clk); #1;
      check("acc_valid", 128'(tt_valid0), 128'd0);
      check("acc_busy", 128'(busy0), 128'd0);
      @(negedge clk) tt_ready0 = 1'b0;
   endtask

   initial begin
      int           cyc;
      int           xbad;
      logic [127:0] tab;
      logic [127:0] hold_tt;
      logic [7:0]   hold_ones;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_busy", 128'(busy0), 128'd0);
      check("rst_x", 128'(x0), 128'd0);
      check("rst_valid", 128'(tt_valid0), 128'd0);
      check("rst_tt", tt0, 128'd0);
      check("rst_ones", 128'(ones0), 128'd0);
      check("rst_state", 128'(st0), 128'(IDLE));
      rst_n = 1'b1;

      // Constant-zero function
      sweep0('0, cyc);
      check("zero_lat", 128'(cyc), 128'd128);
      check("zero_tt", tt0, 128'd0);
      check("zero_ones", 128'(ones0), 128'd0);
      accept0();

      // f = x0
      sweep0(tab_from_rule(1), cyc);
      check("x0_lat", 128'(cyc), 128'd128);
      check("x0_tt", tt0, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
      check("x0_ones", 128'(ones0), 128'd64);
      accept0();

      // f = x6
      sweep0(tab_from_rule(2), cyc);
      check("x6_tt", tt0, {64'hffffffffffffffff, 64'h0});
      check("x6_ones", 128'(ones0), 128'd64);
      accept0();

      // Majority network
      sweep0(MAJ_TT, cyc);
      check("maj_tt", tt0, MAJ_TT);
      check("maj_ones", 128'(ones0), 128'(popcnt(MAJ_TT)));
      check("maj_x_done", 128'(x0), 128'd127);
      accept0();

      // Random functions
      for (int r = 0; r < 3; r++) begin
         tab = rand_tab();
         sweep0(tab, cyc);
         check("rnd_lat", 128'(cyc), 128'd128);
         check("rnd_tt", tt0, tab);
         check("rnd_ones", 128'(ones0), 128'(popcnt(tab)));
         accept0();
      end

      // Hold in DONE with start pulsed; start also high in the accept cycle
      tab = rand_tab();
      sweep0(tab, cyc);
      hold_tt   = tab;
      hold_ones = 8'(popcnt(tab));
      for (int c = 0; c < 10; c++) begin
         @(negedge clk) start0 = (c == 4 || c == 5);
         @(posedge clk); #1;
         check("hold_valid", 128'(tt_valid0), 128'd1);
         check("hold_busy", 128'(busy0), 128'd1);
         check("hold_tt", tt0, hold_tt);
         check("hold_ones", 128'(ones0), 128'(hold_ones));
      end
      @(negedge clk) begin tt_ready0 = 1'b1; start0 = 1'b1; end
      @(posedge clk); #1;
      check("hs_state", 128'(st0), 128'(IDLE));
      check("hs_valid", 128'(tt_valid0), 128'd0);
      check("hs_busy", 128'(busy0), 128'd0);
      @(negedge clk) begin tt_ready0 = 1'b0; start0 = 1'b0; end
      @(posedge clk); #1;
      check("post_state", 128'(st0), 128'(IDLE));
      check("post_tt", tt0, hold_tt);
      check("post_ones", 128'(ones0), 128'(hold_ones));

      // Reset mid-sweep at x=50
      fn_tab0 = rand_tab();
      @(negedge clk) start0 = 1'b1;
      @(negedge clk) start0 = 1'b0;
      cyc = 0;
      while (x0 !== 7'd50 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("mid_reached", 128'(x0), 128'd50);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      check("mid_busy", 128'(busy0), 128'd0);
      check("mid_x", 128'(x0), 128'd0);
      check("mid_valid", 128'(tt_valid0), 128'd0);
      check("mid_tt", tt0, 128'd0);
      check("mid_ones", 128'(ones0), 128'd0);
      check("mid_state", 128'(st0), 128'(IDLE));
      @(negedge clk) rst_n = 1'b1;
      tab = rand_tab();
      sweep0(tab, cyc);
      check("rerun_lat", 128'(cyc), 128'd128);
      check("rerun_tt", tt0, tab);
      check("rerun_ones", 128'(ones0), 128'(popcnt(tab)));
      accept0();

      // Settle of two cycles with a registered function
      tab = rand_tab();
      fn_tab2 = tab;
      repeat (3) @(posedge clk);
      @(negedge clk) start2 = 1'b1;
      @(posedge clk); #1;
      check("s2_start_busy", 128'(busy2), 128'd1);
      check("s2_start_x", 128'(x2), 128'd0);
      @(negedge clk) start2 = 1'b0;
      cyc  = 0;
      xbad = 0;
      while (tt_valid2 !== 1'b1 && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (x2 !== 7'((cyc / 3 > 127) ? 127 : cyc / 3)) xbad++;
      end
      check("s2_lat", 128'(cyc), 128'd384);
      check("s2_x_hold", 128'(xbad), 128'd0);
      check("s2_tt", tt2, tab);
      check("s2_ones", 128'(ones2), 128'(popcnt(tab)));
      @(negedge clk) tt_ready2 = 1'b1;
      @(posedge clk); #1;
      check("s2_acc_valid", 128'(tt_valid2), 128'd0);
      @(negedge clk) tt_ready2 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
